cache_pmem_arbiter: RTL
=======================

# cache_pmem_arbiter

Two-requester arbiter between the instruction cache and the data cache. It merges both onto the single 128-bit line-granular physical-memory port. Each cache's pmem-side outputs feed this block. The block grants one line transaction at a time, latches that transaction's address, data and operation, forwards the memory response to the owner only, and breaks ties round-robin.

## Interface
- No parameters. Line width is fixed at 128 bits and address width at 16 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_pmem_read  in  1  I-cache line read request.
- i_pmem_write  in  1  I-cache line write request.
- i_pmem_address  in  16  I-cache line address.
- i_pmem_wdata  in  128  I-cache write line.
- i_pmem_resp  out  1  response to the I-cache.
- i_pmem_rdata  out  128  read line to the I-cache.
- d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata  in  1/1/16/128  data-cache request; same meaning as the I-cache signals.
- d_pmem_resp, d_pmem_rdata  out  1/128  response to the data cache.
- pmem_read  out  1  read strobe to physical memory.
- pmem_write  out  1  write strobe to physical memory.
- pmem_address  out  16  latched line address.
- pmem_wdata  out  128  latched write line.
- pmem_resp  in  1  physical-memory completion, 1 cycle.
- pmem_rdata  in  128  read line, valid while pmem_resp is high.

## Operation
- States:
  - IDLE: no grant.
  - SERVE_I: I-cache transaction in flight.
  - SERVE_D: data-cache transaction in flight.
- A side is pending when its read or write is high.
- If a single side sets both read and write, the write wins and the read is ignored.
- IDLE transitions:
  - Neither side pending: stay in IDLE.
  - Only one side pending: go to that side's SERVE state.
  - Both pending: grant the side opposite last_grant.
- On every grant:
  - Set last_grant to the granted side.
  - Latch address, wdata and op (op = read or write) into registers.
- SERVE_x:
  - Drive pmem_address and pmem_wdata from the latched registers.
  - Drive pmem_read = (op==read) and pmem_write = (op==write).
  - These drives hold steady until pmem_resp, even if the requester changes or drops its inputs.
- When pmem_resp is high in SERVE_x:
  - x_pmem_resp = 1 combinationally in the same cycle.
  - x_pmem_rdata = pmem_rdata.
  - Next state is IDLE.
- The non-owner's resp is always 0.
- Both rdata outputs are tied to pmem_rdata. Caches qualify rdata with their resp.
- pmem_resp arriving in IDLE is ignored and forwarded to nobody.
- Requester rule: in the cycle after its resp, a requester must either deassert its request or present a new one. The arbiter samples requests only in IDLE.
- Reset (rst_n low at an edge), including mid-transaction:
  - state = IDLE and last_grant = I, so D wins the first tie.
  - Latched address, wdata and op are cleared to 0.
  - All outputs are 0 from the following cycle.
  - An abandoned in-flight transaction is not replayed.

## Timing
- Request seen in IDLE in cycle t: grant at edge t; pmem_read or pmem_write is high in cycle t+1.
- Response: zero-cycle pass-through, pmem_resp in cycle n gives x_pmem_resp in cycle n.
- After each response the arbiter is in IDLE for exactly 1 cycle.
- Minimum cost per transaction:
  - 1 cycle of arbitration.
  - Plus the memory latency.
  - Plus 1 cycle of IDLE turnaround.
- Back-to-back contention alternates I, D, I, D, so neither side is starved. Worst-case wait is one foreign transaction plus 2 cycles.
- Outputs come from registered state and latches, with no combinational path from requester inputs to pmem_*.
- The only combinational paths are pmem_resp/pmem_rdata to x_pmem_resp/x_pmem_rdata.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both caches requesting.
  - Expect all outputs 0 and state IDLE.
  - On release with both sides pending, D is granted first.
- Single I read:
  - Stimulus: i_pmem_read=1, address 0x1230; memory responds 3 cycles later with rdata 0xDEAD…BEEF.
  - Expect pmem_read=1 and pmem_address=0x1230 from the next cycle.
  - Expect i_pmem_resp=1 and i_pmem_rdata=0xDEAD…BEEF in the resp cycle.
  - Expect d_pmem_resp=0 throughout.
- Simultaneous requests:
  - Stimulus: both sides hold requests (I read 0x0100, D write 0x0200 with wdata 0xA5…A5) for 4 transactions.
  - Expect grant order D, I, D, I, with pmem_wdata=0xA5…A5 during each D write.
  - Expect each side's resp asserted only in its own transaction.
- Input change mid-transaction:
  - Stimulus: D read at 0x0400; the D-cache switches its address to 0x0800 and its op to write before pmem_resp.
  - Expect pmem_address to stay 0x0400 and pmem_read to stay 1 until the response.
- Read+write conflict and stray response:
  - Stimulus: i_pmem_read and i_pmem_write both high.
  - Expect pmem_write=1 and pmem_read=0.
  - Stimulus: pulse pmem_resp while in IDLE.
  - Expect both caches' resp to stay 0.
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 during a SERVE_D.
  - Expect pmem_read and pmem_write to be 0 in the next cycle.
  - Expect a later pmem_resp not to be forwarded.
  - Expect a fresh request to be granted normally.

Source files
------------

// File: rtl/cache_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_pmem_arbiter
// Purpose  : Merges the I-cache and D-cache line-granular physical-memory
//            ports onto a single 128-bit memory port. One line transaction is
//            granted at a time. Its address, write data and operation are
//            latched at grant. Ties are broken round-robin. The memory
//            response is forwarded only to the side that owns the transaction.
// Ports    :
//   clk, rst_n                      clock, synchronous active-low reset
//   i_pmem_read/write/address/wdata I-cache request (in)
//   i_pmem_resp/rdata               I-cache response (out)
//   d_pmem_read/write/address/wdata D-cache request (in)
//   d_pmem_resp/rdata               D-cache response (out)
//   pmem_read/write/address/wdata   physical-memory request (out, registered)
//   pmem_resp/rdata                 physical-memory response (in)
// Revision : 1.0 - initial release
// ============================================================================
module cache_pmem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  // I-cache side
  input  logic         i_pmem_read,
  input  logic         i_pmem_write,
  input  logic [15:0]  i_pmem_address,
  input  logic [127:0] i_pmem_wdata,
  output logic         i_pmem_resp,
  output logic [127:0] i_pmem_rdata,
  // D-cache side
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic         d_pmem_resp,
  output logic [127:0] d_pmem_rdata,
  // Physical memory side
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_last_grant_d;  // 0: I-cache was granted last, 1: D-cache
  logic [15:0]    r_addr;
  logic [127:0]   r_wdata;
  logic           r_op_write;      // 1: write transaction, 0: read

  logic           w_i_pend;
  logic           w_d_pend;
  logic           w_grant_i;
  logic           w_grant_d;

  assign w_i_pend = i_pmem_read | i_pmem_write;
  assign w_d_pend = d_pmem_read | d_pmem_write;

  // Next-state and grant decode. Requests are only looked at in IDLE, so
  // requester activity during a transaction cannot disturb it.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // D wins when it is alone or when I was the last side served.
        w_grant_d = w_d_pend & (~w_i_pend | ~r_last_grant_d);
        w_grant_i = w_i_pend & ~w_grant_d;
        if (w_grant_d) begin
          w_state_next = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_state_next = ST_SERVE_I;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (pmem_resp) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant_d <= 1'b0;
      r_addr         <= 16'd0;
      r_wdata        <= 128'd0;
      r_op_write     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // A write request dominates a simultaneous read from the same side.
      if (w_grant_d) begin
        r_last_grant_d <= 1'b1;
        r_addr         <= d_pmem_address;
        r_wdata        <= d_pmem_wdata;
        r_op_write     <= d_pmem_write;
      end else if (w_grant_i) begin
        r_last_grant_d <= 1'b0;
        r_addr         <= i_pmem_address;
        r_wdata        <= i_pmem_wdata;
        r_op_write     <= i_pmem_write;
      end
    end
  end

  // Memory-side drives come only from registered state and latches.
  assign pmem_read    = (r_state != ST_IDLE) & ~r_op_write;
  assign pmem_write   = (r_state != ST_IDLE) &  r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // Zero-cycle response pass-through to the owner only; a response in IDLE
  // reaches nobody.
  assign i_pmem_resp  = pmem_resp & (r_state == ST_SERVE_I);
  assign d_pmem_resp  = pmem_resp & (r_state == ST_SERVE_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
`default_nettype wire
